timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_if.sv | 24 ++
 rtl/timer_ctrl.sv | 149 ++++++++++++++
 tb/tb_timer_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// Button/counter-status inputs and counter-control/display outputs of timer_ctrl.
interface timer_ctrl_if;
  logic       start;
  logic       stop;
  logic       mode;
  logic       cnt_zero;
  logic       cnt_max;
  logic       cnt_en;
  logic       cnt_dir;
  logic       cnt_clr;
  logic       blank;
  logic       alarm;
  logic [1:0] state;

  modport master (
    output start, stop, mode, cnt_zero, cnt_max,
    input  cnt_en, cnt_dir, cnt_clr, blank, alarm, state
  );

  modport slave (
    input  start, stop, mode, cnt_zero, cnt_max,
    output cnt_en, cnt_dir, cnt_clr, blank, alarm, state
  );
endinterface

// File: rtl/timer_ctrl.sv
// Stopwatch/timer control FSM driving an external 4-digit BCD counter and display.
module timer_ctrl #(
  parameter int TICK_DIV    = 1000,
  parameter int ALARM_TICKS = 5,
  parameter int BLINK_DIV   = 250
) (
  input logic         clk,
  input logic         rst,
  timer_ctrl_if.slave bus
);
  localparam int PW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam int BW = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_TICKS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          dir_q, dir_d;
  logic          en_pend_q, en_pend_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          blank_q, blank_d;
  logic          alarm_q, alarm_d;
  logic          start_prev_q, stop_prev_q, mode_prev_q;
  logic          armed_q;

  logic start_ev, stop_ev, mode_ev;
  logic pre_wrap, terminal, bcnt_wrap;

  // armed_q masks the first edge after reset so a button held through release
  // is only captured as a level, never as an event.
  assign start_ev  = armed_q & bus.start & ~start_prev_q;
  assign stop_ev   = armed_q & bus.stop  & ~stop_prev_q;
  assign mode_ev   = armed_q & bus.mode  & ~mode_prev_q;
  assign pre_wrap  = (pre_q == PRE_LAST);
  assign bcnt_wrap = (bcnt_q == BLK_LAST);
  assign terminal  = dir_q ? bus.cnt_zero : bus.cnt_max;

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    acnt_d    = acnt_q;
    dir_d     = dir_q;
    en_pend_d = 1'b0;
    cnt_clr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (stop_ev) begin
          cnt_clr_d = 1'b1;
        end else if (start_ev) begin
          state_d = RUN;
          pre_d   = '0;
        end
        if (mode_ev) dir_d = ~dir_q;
      end
      RUN: begin
        if (stop_ev) begin
          state_d = PAUSE;
        end else begin
          pre_d = pre_wrap ? '0 : pre_q + PW'(1);
          if (pre_wrap) begin
            if (terminal) begin
              state_d = ALARM;
              acnt_d  = '0;
            end else begin
              en_pend_d = 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      ALARM: begin
        pre_d = pre_wrap ? '0 : pre_q + PW'(1);
        if (start_ev || stop_ev) begin
          state_d = IDLE;
        end else if (pre_wrap) begin
          if (acnt_q == ALM_LAST) state_d = IDLE;
          else                    acnt_d  = acnt_q + AW'(1);
        end
      end
    endcase

    // The tick is delayed one cycle after the wrap; drop it if RUN is being left.
    cnt_en_d = en_pend_q && (state_d == RUN);
    alarm_d  = (state_d == ALARM);
    bcnt_d   = bcnt_wrap ? '0 : bcnt_q + BW'(1);
    if (state_d == PAUSE || state_d == ALARM) blank_d = bcnt_wrap ? ~blank_q : blank_q;
    else                                      blank_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      acnt_q       <= '0;
      bcnt_q       <= '0;
      dir_q        <= 1'b0;
      en_pend_q    <= 1'b0;
      cnt_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      blank_q      <= 1'b0;
      alarm_q      <= 1'b0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      mode_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      acnt_q       <= acnt_d;
      bcnt_q       <= bcnt_d;
      dir_q        <= dir_d;
      en_pend_q    <= en_pend_d;
      cnt_en_q     <= cnt_en_d;
      cnt_clr_q    <= cnt_clr_d;
      blank_q      <= blank_d;
      alarm_q      <= alarm_d;
      start_prev_q <= bus.start;
      stop_prev_q  <= bus.stop;
      mode_prev_q  <= bus.mode;
      armed_q      <= 1'b1;
    end
  end

  assign bus.state   = state_q;
  assign bus.cnt_en  = cnt_en_q;
  assign bus.cnt_dir = dir_q;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.blank   = blank_q;
  assign bus.alarm   = alarm_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4, ALARM_TICKS=2, BLINK_DIV=3.
module tb_timer_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  timer_ctrl_if bus();

  timer_ctrl #(
    .TICK_DIV   (4),
    .ALARM_TICKS(2),
    .BLINK_DIV  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, mode, cz, cm;
    int         reps;
    logic [1:0] st;
    logic       en, clr, dir, alm, bchk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic sp, input logic md, input logic z,
                     input logic m, input int reps, input logic [1:0] st,
                     input logic en, input logic clr, input logic dir,
                     input logic alm, input logic bchk);
    vec_t v;
    v.start = s; v.stop = sp; v.mode = md; v.cz = z; v.cm = m; v.reps = reps;
    v.st = st; v.en = en; v.clr = clr; v.dir = dir; v.alm = alm; v.bchk = bchk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d] @%0t: got %0d expected %0d", nm, idx, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic sp, input logic md,
                       input logic z, input logic m);
    bus.start = s; bus.stop = sp; bus.mode = md; bus.cnt_zero = z; bus.cnt_max = m;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_state"}, 0, int'(bus.state), 0);
    chk({nm, "_en"},    0, int'(bus.cnt_en), 0);
    chk({nm, "_clr"},   0, int'(bus.cnt_clr), 0);
    chk({nm, "_dir"},   0, int'(bus.cnt_dir), 0);
    chk({nm, "_blank"}, 0, int'(bus.blank), 0);
    chk({nm, "_alarm"}, 0, int'(bus.alarm), 0);
  endtask

  // cnt_en and cnt_clr must never overlap.
  always @(negedge clk) begin
    if (n_chk > 0) chk("en_clr_excl", 0, int'(bus.cnt_en & bus.cnt_clr), 0);
  end

  initial begin
    int   ntog;
    int   last;
    logic pb;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b1;

    //  st sp md cz cm reps state en clr dir alm bchk
    add(0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 3, 2'd1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 3, 2'd1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd1, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10, 2'd2, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 2, 2'd1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd1, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 2'd0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 2'd0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 1, 2'd1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 3, 2'd1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1, 2'd3, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 7, 2'd3, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 2'd0, 0, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 1, 2'd0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2'd1, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 1, 2'd1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 1, 2'd2, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 2'd1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 2, 2'd1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd1, 1, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 1, 2'd2, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 2'd0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 1, 2'd0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 1, 2'd1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 3, 2'd1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 2'd3, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].cz, vecs[i].cm);
        step();
        chk("state",   i, int'(bus.state),   int'(vecs[i].st));
        chk("cnt_en",  i, int'(bus.cnt_en),  int'(vecs[i].en));
        chk("cnt_clr", i, int'(bus.cnt_clr), int'(vecs[i].clr));
        chk("cnt_dir", i, int'(bus.cnt_dir), int'(vecs[i].dir));
        chk("alarm",   i, int'(bus.alarm),   int'(vecs[i].alm));
        if (vecs[i].bchk) chk("blank", i, int'(bus.blank), 0);
      end
    end

    // Blink period in PAUSE
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0); step();
    chk("pause_entry", 0, int'(bus.state), 2);
    drive(0, 0, 0, 0, 0);
    pb   = bus.blank;
    last = -1;
    ntog = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.blank !== pb) begin
        if (last >= 0) chk("blank_period", c, c - last, 3);
        last = c;
        ntog++;
      end
      pb = bus.blank;
    end
    chk("blank_toggles", 0, ntog, 4);
    drive(0, 1, 0, 0, 0); step();
    chk("pause_exit_state", 0, int'(bus.state), 0);
    chk("pause_exit_clr",   0, int'(bus.cnt_clr), 1);
    chk("idle_blank",       0, int'(bus.blank), 0);
    drive(0, 0, 0, 0, 0); step();

    // Async reset while in ALARM, start held through release
    drive(0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 1, 0); step();
    drive(1, 0, 0, 1, 0); step();
    drive(0, 0, 0, 1, 0);
    for (int c = 0; c < 4; c++) step();
    chk("alarm_entry_state", 0, int'(bus.state), 3);
    chk("alarm_entry_dir",   0, int'(bus.cnt_dir), 1);
    drive(1, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_alarm");
    step();
    chk_all_zero("rst_hold");
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("held_start_idle", c, int'(bus.state), 0);
    end
    drive(0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0); step();
    chk("repress_run", 0, int'(bus.state), 1);

    // Reset right after a wrap must swallow the pending tick
    drive(0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) step();
    chk("prewrap_en", 0, int'(bus.cnt_en), 0);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_run");
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_run_en", c, int'(bus.cnt_en), 0);
    end
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_rst_en",    c, int'(bus.cnt_en), 0);
      chk("post_rst_state", c, int'(bus.state), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
